// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: line synchronisers, ps2_clk glitch filter, 11-bit
// frame deserialiser, 3-byte packet assembly and clamped cursor accumulation.
// Optional host-side init sequence (reset, inhibit, send 0xF4, wait for 0xFA)
// is compiled in when PS2_MOUSE_INIT_EN is defined. Without it the block
// starts in run mode and never drives the PS/2 lines.
`timescale 1ns/1ps
module ps2_mouse_rx #(
  parameter int CLK_HZ     = 75_000_000,
  parameter int X_MAX      = 1023,
  parameter int Y_MAX      = 767,
  parameter int FILTER_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         ps2_clk,
  inout  wire         ps2_data,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [2:0]  btn,
  output logic        pkt_valid,
  output logic        err
);
  localparam int TO_CYC = CLK_HZ / 500;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_filt_q;
  logic [FL_W-1:0] filt_cnt_q;
  logic            fall_s;
  logic [3:0]      bit_cnt_q;
  logic [9:0]      sh_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [1:0]      byte_cnt_q;
  logic [6:0]      hdr_q;      // {yov, xov, ys, xs, m, r, l}
  logic [7:0]      b1_q;
  logic [11:0]     xpos_q, ypos_q;
  logic [2:0]      btn_q;
  logic            pkt_valid_q, err_q;
  logic            frame_done_s, frame_ok_s, frame_bad_s, timeout_s, sync_err_s;
  logic [7:0]      rx_byte_s;
  logic signed [12:0] dx_s, dy_s, x_sum_s, y_sum_s;
  logic [11:0]     x_new_s, y_new_s;
  logic            rx_en_s, run_s, drv_clk_s, drv_dat_s;

  // Open-collector outputs: either pull low or release.
  assign ps2_clk  = drv_clk_s ? 1'b0 : 1'bz;
  assign ps2_data = drv_dat_s ? 1'b0 : 1'bz;

  // Synchronise both lines and accept a new ps2_clk level only after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= {FL_W{1'b0}};
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= {FL_W{1'b0}};
      end else if (filt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= {FL_W{1'b0}};
      end else begin
        filt_cnt_q <= filt_cnt_q + FL_W'(1);
      end
    end
  end

  // Frame decode: falling edge, stop-bit checks, timeout and sync errors.
  always_comb begin
    fall_s       = clk_filt_q & ~clk_sync_q[1] & (filt_cnt_q == FL_W'(FILTER_LEN - 1));
    rx_byte_s    = sh_q[8:1];
    frame_done_s = rx_en_s & fall_s & (bit_cnt_q == 4'd10);
    frame_ok_s   = frame_done_s & ~sh_q[0] & (^sh_q[9:1]) & dat_sync_q[1];
    frame_bad_s  = frame_done_s & ~frame_ok_s;
    timeout_s    = rx_en_s & ~fall_s & (bit_cnt_q != 4'd0) & (to_cnt_q == TO_W'(TO_CYC - 1));
    sync_err_s   = frame_ok_s & run_s & (byte_cnt_q == 2'd0) & ~rx_byte_s[3];
  end

  // Signed delta accumulation with clamping to the screen rectangle.
  always_comb begin
    if (hdr_q[5]) begin
      dx_s = 13'sd0;
    end else begin
      dx_s = $signed({{4{hdr_q[3]}}, hdr_q[3], b1_q});
    end
    if (hdr_q[6]) begin
      dy_s = 13'sd0;
    end else begin
      dy_s = $signed({{4{hdr_q[4]}}, hdr_q[4], rx_byte_s});
    end
    x_sum_s = $signed({1'b0, xpos_q}) + dx_s;
    y_sum_s = $signed({1'b0, ypos_q}) - dy_s;
    if (x_sum_s < 13'sd0) begin
      x_new_s = 12'd0;
    end else if (x_sum_s > $signed(13'(X_MAX))) begin
      x_new_s = 12'(X_MAX);
    end else begin
      x_new_s = x_sum_s[11:0];
    end
    if (y_sum_s < 13'sd0) begin
      y_new_s = 12'd0;
    end else if (y_sum_s > $signed(13'(Y_MAX))) begin
      y_new_s = 12'(Y_MAX);
    end else begin
      y_new_s = y_sum_s[11:0];
    end
  end

  // Bit/byte counters, frame timeout, packet assembly and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= 4'd0;
      sh_q        <= 10'd0;
      to_cnt_q    <= {TO_W{1'b0}};
      byte_cnt_q  <= 2'd0;
      hdr_q       <= 7'd0;
      b1_q        <= 8'd0;
      xpos_q      <= 12'((X_MAX + 1) / 2);
      ypos_q      <= 12'((Y_MAX + 1) / 2);
      btn_q       <= 3'd0;
      pkt_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (!rx_en_s || timeout_s) begin
      bit_cnt_q   <= 4'd0;
      to_cnt_q    <= {TO_W{1'b0}};
      byte_cnt_q  <= 2'd0;
      pkt_valid_q <= 1'b0;
      err_q       <= timeout_s;
    end else begin
      pkt_valid_q <= 1'b0;
      err_q       <= frame_bad_s | sync_err_s;
      if (fall_s) begin
        to_cnt_q <= {TO_W{1'b0}};
        if (frame_done_s) begin
          bit_cnt_q <= 4'd0;
          if (frame_bad_s) begin
            byte_cnt_q <= 2'd0;
          end else if (run_s) begin
            case (byte_cnt_q)
              2'd0: begin
                if (rx_byte_s[3]) begin
                  hdr_q      <= {rx_byte_s[7:4], rx_byte_s[2:0]};
                  byte_cnt_q <= 2'd1;
                end
              end
              2'd1: begin
                b1_q       <= rx_byte_s;
                byte_cnt_q <= 2'd2;
              end
              2'd2: begin
                xpos_q      <= x_new_s;
                ypos_q      <= y_new_s;
                btn_q       <= hdr_q[2:0];
                pkt_valid_q <= 1'b1;
                byte_cnt_q  <= 2'd0;
              end
              default: byte_cnt_q <= 2'd0;
            endcase
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          sh_q      <= {dat_sync_q[1], sh_q[9:1]};
        end
      end else if (bit_cnt_q != 4'd0) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign btn       = btn_q;
  assign pkt_valid = pkt_valid_q;
  assign err       = err_q;

`ifdef PS2_MOUSE_INIT_EN
  typedef enum logic [2:0] {S_WAIT, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_FA, S_RUN} init_st_e;
  localparam logic [31:0] WAIT_CYC = 32'(CLK_HZ / 10);
  localparam logic [31:0] INH_CYC  = 32'(CLK_HZ / 10000);
  localparam logic [31:0] RSP_CYC  = 32'(CLK_HZ / 50);

  init_st_e    st_q, st_d;
  logic [31:0] icnt_q, icnt_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic [8:0]  tx_sh_q, tx_sh_d;
  logic        drv_clk_q, drv_clk_d, drv_dat_q, drv_dat_d;
  logic        fa_seen_s;

  assign fa_seen_s = frame_ok_s & (rx_byte_s == 8'hFA);
  assign rx_en_s   = (st_q == S_WAIT_FA) || (st_q == S_RUN);
  assign run_s     = (st_q == S_RUN);
  assign drv_clk_s = drv_clk_q;
  assign drv_dat_s = drv_dat_q;

  // Init FSM state, timers and registered line drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_WAIT;
      icnt_q    <= 32'd0;
      tx_cnt_q  <= 4'd0;
      tx_sh_q   <= 9'd0;
      drv_clk_q <= 1'b0;
      drv_dat_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      icnt_q    <= icnt_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_sh_q   <= tx_sh_d;
      drv_clk_q <= drv_clk_d;
      drv_dat_q <= drv_dat_d;
    end
  end

  // Init FSM next state: inhibit, request-to-send 0xF4, check ACK, wait for 0xFA.
  always_comb begin
    st_d      = st_q;
    icnt_d    = icnt_q + 32'd1;
    tx_cnt_d  = tx_cnt_q;
    tx_sh_d   = tx_sh_q;
    drv_clk_d = 1'b0;
    drv_dat_d = 1'b0;
    case (st_q)
      S_WAIT: begin
        if (icnt_q >= WAIT_CYC - 32'd1) begin
          st_d = S_INHIBIT; icnt_d = 32'd0;
        end else begin
          st_d = S_WAIT;
        end
      end
      S_INHIBIT: begin
        drv_clk_d = 1'b1;
        if (icnt_q >= INH_CYC - 32'd1) begin
          st_d = S_REQ; icnt_d = 32'd0;
        end else begin
          st_d = S_INHIBIT;
        end
      end
      S_REQ: begin
        drv_clk_d = 1'b1;
        drv_dat_d = 1'b1;
        st_d      = S_SEND;
        icnt_d    = 32'd0;
        tx_cnt_d  = 4'd0;
        tx_sh_d   = {1'b0, 8'hF4};   // parity 0: 0xF4 already has an odd number of ones
      end
      S_SEND: begin
        drv_dat_d = drv_dat_q;
        if (icnt_q >= RSP_CYC - 32'd1) begin
          st_d = S_INHIBIT; icnt_d = 32'd0; drv_dat_d = 1'b0;
        end else if (fall_s) begin
          if (tx_cnt_q == 4'd9) begin
            drv_dat_d = 1'b0;      // release for the stop bit
            st_d      = S_ACK;
          end else begin
            drv_dat_d = ~tx_sh_q[0];
            tx_sh_d   = {1'b1, tx_sh_q[8:1]};
            tx_cnt_d  = tx_cnt_q + 4'd1;
          end
        end else begin
          st_d = S_SEND;
        end
      end
      S_ACK: begin
        if (icnt_q >= RSP_CYC - 32'd1) begin
          st_d = S_INHIBIT; icnt_d = 32'd0;
        end else if (fall_s) begin
          icnt_d = 32'd0;
          if (!dat_sync_q[1]) begin
            st_d = S_WAIT_FA;
          end else begin
            st_d = S_INHIBIT;
          end
        end else begin
          st_d = S_ACK;
        end
      end
      S_WAIT_FA: begin
        if (fa_seen_s) begin
          st_d = S_RUN;
        end else if (icnt_q >= RSP_CYC - 32'd1) begin
          st_d = S_INHIBIT; icnt_d = 32'd0;
        end else begin
          st_d = S_WAIT_FA;
        end
      end
      S_RUN: begin
        icnt_d = icnt_q;
      end
      default: begin
        st_d = S_WAIT; icnt_d = 32'd0;
      end
    endcase
  end
`else
  assign rx_en_s   = 1'b1;
  assign run_s     = 1'b1;
  assign drv_clk_s = 1'b0;
  assign drv_dat_s = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx (default build, no init FSM).
// A device model clocks frames onto the lines; a table of hand-computed
// packets, corner-case sequences and randomized packets checked against an
// integer reference model.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;
  localparam int HALF   = 16;        // PS/2 half bit period in system cycles
  localparam int GAP    = 40;
  localparam int CLK_HZ = 500_000;   // timeout = 1000 cycles
  localparam int XMAX   = 1023;
  localparam int YMAX   = 767;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_clk = 1'b1;
  logic tb_dat = 1'b1;
  logic tb_en = 1'b1;
  wire  ps2_clk_w, ps2_dat_w;
  logic [11:0] xpos, ypos;
  logic [2:0]  btn;
  logic        pkt_valid, err;

  assign ps2_clk_w = tb_en ? tb_clk : 1'bz;
  assign ps2_dat_w = tb_en ? tb_dat : 1'bz;

  ps2_mouse_rx #(.CLK_HZ(CLK_HZ), .X_MAX(XMAX), .Y_MAX(YMAX), .FILTER_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk_w), .ps2_data(ps2_dat_w),
    .xpos(xpos), .ypos(ypos), .btn(btn), .pkt_valid(pkt_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int pv_cnt = 0, err_cnt = 0;
  int mx, my, mbtn;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int ex, ey, ebtn;
  } vec_t;
  vec_t vecs [10];

  // Count high cycles of the strobes (one per event when they are single-cycle).
  always @(negedge clk) begin
    if (pkt_valid === 1'b1) pv_cnt <= pv_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tb_dat = b;
    wait_cyc(HALF);
    tb_clk = 1'b0;
    wait_cyc(HALF);
    tb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(bad_par ? ^d : ~^d);
    send_bit(1'b1);
    wait_cyc(GAP);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0);
    send_frame(b1, 1'b0);
    send_frame(b2, 1'b0);
  endtask

  // Reference: 9-bit signed deltas, overflow zeroes the axis, +Y is up, clamp.
  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    if (b0[6]) dx = 0;
    else dx = b0[4] ? int'(b1) - 256 : int'(b1);
    if (b0[7]) dy = 0;
    else dy = b0[5] ? int'(b2) - 256 : int'(b2);
    mx = mx + dx;
    if (mx < 0) mx = 0;
    if (mx > XMAX) mx = XMAX;
    my = my - dy;
    if (my < 0) my = 0;
    if (my > YMAX) my = YMAX;
    mbtn = int'(b0[2:0]);
  endtask

  task automatic model_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int p0;
    p0 = pv_cnt;
    send_packet(b0, b1, b2);
    model_apply(b0, b1, b2);
    chk({tag, " xpos"}, int'(xpos), mx);
    chk({tag, " ypos"}, int'(ypos), my);
    chk({tag, " btn"}, int'(btn), mbtn);
    chk({tag, " pkt_valid count"}, pv_cnt - p0, 1);
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int p0, e0;
    logic [7:0] r0, r1, r2;
    vecs[0] = '{8'h09, 8'h10, 8'hF0, 528, 144, 1};
    vecs[1] = '{8'h38, 8'h00, 8'h00, 272, 400, 0};
    vecs[2] = '{8'h38, 8'h00, 8'h00,  16, 656, 0};
    vecs[3] = '{8'h38, 8'h00, 8'h00,   0, 767, 0};
    vecs[4] = '{8'h38, 8'h00, 8'h00,   0, 767, 0};
    vecs[5] = '{8'h4A, 8'h7F, 8'h01,   0, 766, 2};
    vecs[6] = '{8'h8C, 8'hFF, 8'h80, 255, 766, 4};
    vecs[7] = '{8'h1F, 8'h80, 8'h7F, 127, 639, 7};
    vecs[8] = '{8'h28, 8'h01, 8'hFF, 128, 640, 0};
    vecs[9] = '{8'h08, 8'hFF, 8'h00, 383, 640, 0};

    // Reset state
    wait_cyc(5);
    chk("reset xpos", int'(xpos), 512);
    chk("reset ypos", int'(ypos), 384);
    chk("reset btn", int'(btn), 0);
    chk("reset pkt_valid", int'(pkt_valid), 0);
    chk("reset err", int'(err), 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Table of packets with hand-computed cumulative positions
    for (int i = 0; i < 10; i++) begin
      p0 = pv_cnt;
      e0 = err_cnt;
      send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      chk($sformatf("vec%0d xpos", i), int'(xpos), vecs[i].ex);
      chk($sformatf("vec%0d ypos", i), int'(ypos), vecs[i].ey);
      chk($sformatf("vec%0d btn", i), int'(btn), vecs[i].ebtn);
      chk($sformatf("vec%0d pkt_valid count", i), pv_cnt - p0, 1);
      chk($sformatf("vec%0d err count", i), err_cnt - e0, 0);
    end
    mx = 383; my = 640; mbtn = 0;

    // Bad parity in byte 1 discards the packet; the next one is accepted
    p0 = pv_cnt; e0 = err_cnt;
    send_frame(8'h09, 1'b0);
    send_frame(8'h10, 1'b1);
    chk("parity err count", err_cnt - e0, 1);
    chk("parity pkt_valid count", pv_cnt - p0, 0);
    chk("parity xpos held", int'(xpos), mx);
    model_packet("after parity", 8'h29, 8'h05, 8'h03);

    // Stream stops after 5 bits: timeout error, then recovery
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    tb_dat = 1'b1;
    wait_cyc(1500);
    chk("timeout err count", err_cnt - e0, 1);
    model_packet("after timeout", 8'h19, 8'hF0, 8'h10);

    // 3-cycle glitch on ps2_clk must not be taken as an edge
    e0 = err_cnt;
    tb_clk = 1'b0;
    wait_cyc(3);
    tb_clk = 1'b1;
    wait_cyc(30);
    chk("glitch err count", err_cnt - e0, 0);
    model_packet("after glitch", 8'h0A, 8'h20, 8'h20);
    chk("glitch err count after packet", err_cnt - e0, 0);

    // Byte 0 with bit 3 clear is rejected; counter stays at byte 0
    p0 = pv_cnt; e0 = err_cnt;
    send_frame(8'h11, 1'b0);
    chk("sync err count", err_cnt - e0, 1);
    chk("sync pkt_valid count", pv_cnt - p0, 0);
    model_packet("after sync", 8'h0C, 8'h03, 8'h04);

    // Reset in the middle of a frame returns outputs at once
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe reset xpos", int'(xpos), 512);
    chk("midframe reset ypos", int'(ypos), 384);
    chk("midframe reset btn", int'(btn), 0);
    wait_cyc(3);
    tb_dat = 1'b1;
    rst_n = 1'b1;
    wait_cyc(20);
    mx = 512; my = 384; mbtn = 0;
    for (int i = 0; i < 3; i++) model_packet($sformatf("clamp%0d", i), 8'h38, 8'h00, 8'h00);
    chk("clamp final xpos", int'(xpos), 0);
    chk("clamp final ypos", int'(ypos), 767);

    // Randomized packets against the reference model
    for (int i = 0; i < 20; i++) begin
      r0 = 8'($urandom_range(0, 255)) | 8'h08;
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      model_packet($sformatf("rand%0d", i), r0, r1, r2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_rx.md
# ps2_mouse_rx

PS/2 mouse front end that owns the board's PS2Clk/PS2Data lines and feeds the game core with a clamped cursor position and button state. It synchronises and de-glitches the open-collector lines, deserialises 11-bit device frames, assembles 3-byte movement packets and accumulates signed deltas into screen coordinates. It runs in the 75 MHz pixel clock domain, directly upstream of the cursor and game logic.

## Interface
- CLK_HZ, 75_000_000, clock frequency; derives timeouts.
- X_MAX, 1023, largest legal xpos.
- Y_MAX, 767, largest legal ypos.
- FILTER_LEN, 8, consecutive equal samples needed to accept a new ps2_clk level.
- clk  in  1  system clock (75 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  inout  1  PS/2 clock; the block only drives 0 or releases to Z.
- ps2_data  inout  1  PS/2 data; the block only drives 0 or releases to Z.
- xpos  out  12  cursor X, 0..X_MAX.
- ypos  out  12  cursor Y, 0..Y_MAX, 0 = top.
- btn  out  3  {middle, right, left}, 1 = pressed.
- pkt_valid  out  1  one-cycle strobe on each accepted packet.
- err  out  1  one-cycle strobe on each rejected frame or timeout.

## Operation
- Both lines pass through 2-FF synchronisers. Filtered ps2_clk changes level only after FILTER_LEN equal consecutive samples. Data is sampled on the filtered falling edge.
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1. A bad start, parity or stop bit discards the byte, pulses err and resets the byte counter to 0.
- Frame timeout: if no falling edge arrives for CLK_HZ/500 cycles (2 ms) with the bit counter nonzero, the bit and byte counters clear and err pulses.
- Byte 0 sync: byte 0 = {yov,xov,ys,xs,1,m,r,l}. If bit 3 is 0 the byte is discarded, err pulses and the byte counter stays 0.
- Deltas are 9-bit signed: dx = {xs,byte1}, dy = {ys,byte2}. A set overflow bit forces that axis delta to 0.
- Accumulation uses 13-bit signed arithmetic: x_new = xpos + dx and y_new = ypos − dy (PS/2 +Y is up). Each result clamps to [0, X_MAX] or [0, Y_MAX].
- The block never drives the lines in RUN.

## Timing
- Reset values: xpos = (X_MAX+1)/2 = 512, ypos = (Y_MAX+1)/2 = 384, btn = 0, pkt_valid = 0, err = 0. Counters clear and both lines are released.
- Pin-to-edge latency: 2 + FILTER_LEN cycles.
- xpos, ypos and btn update on the clock edge after the third byte's stop bit is sampled. pkt_valid is high for exactly that cycle.
- err is high for exactly one cycle per event. If a packet completion and an err event fall in the same cycle, the packet completes and err is also asserted.
- If rst_n asserts mid-frame, the partial frame is lost and outputs return to reset values immediately. The block resynchronises on the next byte whose bit 3 is 1.

## Configuration
- PS2_MOUSE_INIT_EN defined: a host-side init FSM runs after reset, with states WAIT, INHIBIT, REQ, SEND, ACK, WAIT_FA, RUN.
  - WAIT: CLK_HZ/10 cycles.
  - INHIBIT: drive ps2_clk low for CLK_HZ/10000 cycles (100 µs).
  - REQ: drive ps2_data low, then release ps2_clk.
  - SEND: shift out 0xF4, LSB first, one bit per device falling edge, then parity 0, then release for stop.
  - ACK: expect the device to pull data low on the next falling edge.
  - WAIT_FA: discard received bytes until 0xFA arrives, then enter RUN.
  - Missing ACK or no 0xFA within CLK_HZ/50 cycles returns to INHIBIT (retry).
  - No packets are decoded before RUN.
- PS2_MOUSE_INIT_EN undefined: the FSM is absent, the block starts in RUN, and both lines stay Z permanently.

## Test plan
- Device model sends packet 0x09, 0x10, 0xF0 (left pressed, dx=+16, dy=+(−16) via ys=0 ⇒ dy=+240) -> one pkt_valid; xpos=528, ypos=144, btn=3'b001.
- Packet 0x38, 0x00, 0x00 (xs=1, ys=1: dx=−256, dy=−256) from reset, repeated 3 times -> xpos clamps at 0 and ypos reaches 767 and holds there. No wrap on any axis.
- Frame with wrong parity inside byte 1 -> err pulses once, no pkt_valid; a following valid 3-byte packet is accepted.
- Bit stream stops after 5 bits for 3 ms -> err pulses once; the next full packet decodes correctly.
- 3-cycle low glitch on ps2_clk (FILTER_LEN=8) -> no bit sampled, no err.
- With PS2_MOUSE_INIT_EN: observe ps2_clk held low ≥7500 cycles, then 0xF4 with parity 0 on data. The model ACKs and sends 0xFA, and the block enters RUN. If the model withholds 0xFA, a second INHIBIT pulse follows.
